// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register stage.
package hilo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DATA_W         = 32;
  localparam int CNT_W          = 6;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/hilo_latency_counter.sv
// Down-counter modelling mult/div latency; done is raised while the count sits at 1.
module hilo_latency_counter
  import hilo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so an idle counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register stage with multi-cycle mult/div commit and collision stall.
// Optional build macro: DIV_ZERO_GUARD_EN (div-by-zero commit leaves HI/LO untouched).
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] in_hi,
  input  logic [31:0] in_lo,
  input  logic        div_zero,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

`ifdef DIV_ZERO_GUARD_EN
  localparam bit DZ_GUARD = 1'b1;
`else
  localparam bit DZ_GUARD = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
  logic              pend_dz_q, pend_dz_d;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_done;

  hilo_latency_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .done     (cnt_done)
  );

  assign busy  = (state_q == BUSY);
  assign stall = busy & (rd_hi | rd_lo | mthi | mtlo | start_mult | start_div);
  assign rdata = rd_hi ? hi_q : (rd_lo ? lo_q : '0);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state_q)
      IDLE: begin
        // Direct writes land now; a start in the same cycle overwrites them at commit.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start_mult) begin
          pend_hi_d = in_hi;
          pend_lo_d = in_lo;
          pend_dz_d = 1'b0;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(MULT_CYCLES);
          state_d   = BUSY;
        end else if (start_div) begin
          pend_hi_d = in_hi;
          pend_lo_d = in_lo;
          pend_dz_d = div_zero;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(DIV_CYCLES);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_done) begin
          if (!(pend_dz_q && DZ_GUARD)) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with default latencies (mult 5, div 32).
module tb_hilo_unit;

  logic        clk;
  logic        reset;
  logic        start_mult, start_div, div_zero;
  logic [31:0] in_hi, in_lo, wdata;
  logic        mthi, mtlo, rd_hi, rd_lo;
  logic [31:0] rdata, hi_q, lo_q;
  logic        busy, stall;

  int vectors = 0;
  int errors  = 0;

  hilo_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .in_hi      (in_hi),
    .in_lo      (in_lo),
    .div_zero   (div_zero),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .rd_hi      (rd_hi),
    .rd_lo      (rd_lo),
    .rdata      (rdata),
    .busy       (busy),
    .stall      (stall),
    .hi_q       (hi_q),
    .lo_q       (lo_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_mult = 0; start_div = 0; div_zero = 0;
    in_hi = '0; in_lo = '0; wdata = '0; mthi = 0; mtlo = 0; rd_hi = 0; rd_lo = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and idle reads
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    check("rst_busy", busy, 1'b0);
    rd_hi = 1; #1;
    check("rst_rdhi", rdata, 32'h0);
    check("rst_stall_hi", stall, 1'b0);
    tick();
    rd_hi = 0; rd_lo = 1; #1;
    check("rst_rdlo", rdata, 32'h0);
    check("rst_stall_lo", stall, 1'b0);
    check("rst_busy2", busy, 1'b0);
    tick();
    rd_lo = 0;

    // Multiply, mfhi held through the busy window
    start_mult = 1; in_hi = 32'h0000_0001; in_lo = 32'h8000_0000;
    tick();
    start_mult = 0; rd_hi = 1; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mult_busy%0d", i), busy, 1'b1);
      check($sformatf("mult_stall%0d", i), stall, 1'b1);
      tick();
    end
    check("mult_busy_end", busy, 1'b0);
    check("mult_stall_end", stall, 1'b0);
    check("mult_rdata", rdata, 32'h0000_0001);
    check("mult_hi", hi_q, 32'h0000_0001);
    check("mult_lo", lo_q, 32'h8000_0000);
    rd_hi = 0;

    // Divide, then a multiply held through busy and accepted right after commit
    start_div = 1; in_hi = 32'd3; in_lo = 32'd7;
    tick();
    start_div = 0; start_mult = 1; in_hi = 32'hAA; in_lo = 32'hBB; #1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("div_stall%0d", i), stall, 1'b1);
      tick();
    end
    check("div_hi", hi_q, 32'd3);
    check("div_lo", lo_q, 32'd7);
    check("div_busy_end", busy, 1'b0);
    check("div_stall_end", stall, 1'b0);
    tick();
    start_mult = 0;
    check("m2_busy", busy, 1'b1);
    repeat (5) tick();
    check("m2_hi", hi_q, 32'hAA);
    check("m2_lo", lo_q, 32'hBB);
    check("m2_busy_end", busy, 1'b0);

    // mthi in idle, then mthi stalled during a multiply
    mthi = 1; wdata = 32'hDEAD_BEEF;
    tick();
    mthi = 0;
    check("mthi_idle", hi_q, 32'hDEAD_BEEF);
    start_mult = 1; in_hi = 32'h11; in_lo = 32'h22;
    tick();
    start_mult = 0; mthi = 1; wdata = 32'h1234_5678; #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mthi_stall%0d", i), stall, 1'b1);
      check($sformatf("mthi_hold%0d", i), hi_q, 32'hDEAD_BEEF);
      tick();
    end
    check("mthi_commit_hi", hi_q, 32'h11);
    check("mthi_commit_lo", lo_q, 32'h22);
    check("mthi_nostall", stall, 1'b0);
    tick();
    mthi = 0;
    check("mthi_after", hi_q, 32'h1234_5678);
    check("mthi_lo_keep", lo_q, 32'h22);

    // Divide by zero over HI/LO = 5/9
    mthi = 1; wdata = 32'd5;
    tick();
    mthi = 0; mtlo = 1; wdata = 32'd9;
    tick();
    mtlo = 0;
    check("dz_pre_hi", hi_q, 32'd5);
    check("dz_pre_lo", lo_q, 32'd9);
    start_div = 1; div_zero = 1; in_hi = 32'hEE; in_lo = 32'hFF;
    tick();
    start_div = 0; div_zero = 0;
    repeat (31) tick();
    check("dz_busy_last", busy, 1'b1);
    tick();
    check("dz_busy_end", busy, 1'b0);
`ifdef DIV_ZERO_GUARD_EN
    check("dz_hi", hi_q, 32'd5);
    check("dz_lo", lo_q, 32'd9);
`else
    check("dz_hi", hi_q, 32'hEE);
    check("dz_lo", lo_q, 32'hFF);
`endif

    // Reset three cycles into a multiply aborts it
    start_mult = 1; in_hi = 32'h77; in_lo = 32'h88;
    tick();
    start_mult = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi_q, 32'h0);
    check("abort_lo", lo_q, 32'h0);
    repeat (8) tick();
    check("abort_hi_late", hi_q, 32'h0);
    check("abort_lo_late", lo_q, 32'h0);

    // Simultaneous starts: multiply wins with its 5-cycle latency
    start_mult = 1; start_div = 1; in_hi = 32'h100; in_lo = 32'h200;
    tick();
    start_mult = 0; start_div = 0;
    repeat (4) tick();
    check("both_busy4", busy, 1'b1);
    tick();
    check("both_busy_end", busy, 1'b0);
    check("both_hi", hi_q, 32'h100);
    check("both_lo", lo_q, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register stage sitting directly downstream of the combinational multiply/divide unit. It captures the 64-bit mult/div result when an operation is issued and models the unit's multi-cycle latency with a countdown. After the countdown it commits the result to HI/LO. It serves mfhi/mflo reads and mthi/mtlo writes, and stalls the pipeline whenever a HI/LO access collides with an operation in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from accepted mult start to HI/LO commit (1..63)
- DIV_CYCLES, 32, cycles from accepted div start to HI/LO commit (1..63)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start_mult  input  1  issue multiply this cycle
- start_div  input  1  issue divide this cycle
- in_hi  input  32  product[63:32] for mult, remainder for div
- in_lo  input  32  product[31:0] for mult, quotient for div
- div_zero  input  1  divisor of current div is zero
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  mthi/mtlo data
- rd_hi  input  1  mfhi request
- rd_lo  input  1  mflo request
- rdata  output  32  HI if rd_hi, else LO if rd_lo, else 0
- busy  output  1  operation in flight
- stall  output  1  requester must hold its request and retry
- hi_q  output  32  current HI
- lo_q  output  32  current LO

## Operation
- States: IDLE, BUSY. Registers: hi_q, lo_q, pend_hi, pend_lo, cnt[5:0].
- IDLE, start_mult=1: capture in_hi/in_lo into pend_*, load cnt=MULT_CYCLES, go BUSY.
- IDLE, start_div=1 (start_mult=0): capture, load cnt=DIV_CYCLES, go BUSY.
- Both starts are asserted together: mult wins, div is dropped.
- BUSY: cnt decrements each cycle. At cnt==1: hi_q<=pend_hi, lo_q<=pend_lo, go IDLE.
- mthi/mtlo in IDLE: write on that edge. If accepted in the same cycle as a start, the write happens and the later commit overwrites it.
- stall = busy & (rd_hi | rd_lo | mthi | mtlo | start_mult | start_div). While stalled, the request has no effect and the requester holds it.
- rdata is combinational from hi_q/lo_q and is valid only when stall=0. rd_hi has priority over rd_lo.
- Arithmetic: cnt is 6-bit unsigned and never wraps; it is loaded only in IDLE.

## Timing
- Reset: hi_q=0, lo_q=0, pend_*=0, cnt=0, state IDLE, busy=0, stall=0, rdata=0.
- A start accepted in cycle T sets busy=1 in cycles T+1..T+N, where N is the op's latency.
- HI/LO take the new value at the end of cycle T+N; it is visible and busy=0 from T+N+1.
- An mfhi at T+N+1 returns the new value with no stall.
- An mfhi issued T+1..T+N stalls until T+N+1.
- A reset asserted mid-operation aborts it: the pending result is discarded and HI/LO clear to 0 on that edge.
- Back-to-back: a new start is accepted no earlier than T+N+1.

## Configuration
- DIV_ZERO_GUARD_EN defined: a div started with div_zero=1 still occupies DIV_CYCLES, but commit leaves hi_q/lo_q unchanged.
- DIV_ZERO_GUARD_EN not defined: in_hi/in_lo are committed regardless of div_zero.

## Structure
- Shared package holds:
  - state enum (IDLE, BUSY)
  - default latency constants MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=32
  - counter width constant CNT_W=6
- One sub-module is natural: hilo_latency_counter. It takes a load with a value and reports done at cnt==1, and is shared by the mult and div paths.

## Test plan
- Reset, then rd_hi=1 and rd_lo=1 on successive cycles: rdata=0 each cycle, busy=0, stall=0.
- start_mult with in_hi=32'h0000_0001, in_lo=32'h8000_0000: busy for 5 cycles, then hi_q=1 and lo_q=32'h8000_0000. An mfhi issued during busy stalls exactly until commit.
- start_div with in_lo=7 (quotient), in_hi=3 (remainder): busy for 32 cycles, then lo_q=7, hi_q=3. A start_mult during busy is stalled, then accepted the cycle after commit.
- mthi wdata=32'hDEAD_BEEF in IDLE: hi_q=32'hDEAD_BEEF next cycle. The same mthi issued while busy stalls, and hi_q is unchanged until after commit.
- start_div with div_zero=1 after HI/LO were set to 5/9: with DIV_ZERO_GUARD_EN, HI/LO stay 5/9 after 32 cycles; without it, they take in_hi/in_lo.
- Reset asserted 3 cycles into a mult: the next cycle shows busy=0 and hi_q=lo_q=0, and no commit occurs afterwards.
